// File: rtl/gate4_accum_unit.sv
// Stateful 4-bit gate datapath: applies NOT/OR/AND/XOR/LOAD to an accumulator CNT+1 times.
// Optional GATE4_ACCUM_FLAGS_EN adds registered ZERO and PARITY result flags.
module gate4_accum_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] B,
    input  logic [CNT_W-1:0] CNT,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES,
    output logic             ERR
`ifdef GATE4_ACCUM_FLAGS_EN
    ,
    output logic             ZERO,
    output logic             PARITY
`endif
);

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpNot  = 3'b001;
    localparam logic [2:0] OpOr   = 3'b010;
    localparam logic [2:0] OpAnd  = 3'b011;
    localparam logic [2:0] OpXor  = 3'b100;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic             op_legal;

    assign op_legal = (OP <= OpXor);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    op_d  = OP;
                    b_d   = B;
                    cnt_d = CNT;
                    if (op_legal) begin
                        state_d = StExec;
                        err_d   = 1'b0;
                    end else begin
                        // Illegal op reports immediately with the accumulator untouched.
                        state_d = StDone;
                        err_d   = 1'b1;
                        res_d   = acc_q;
                    end
                end
            end
            StExec: begin
                case (op_q)
                    OpLoad:  acc_d = b_q;
                    OpNot:   acc_d = ~acc_q;
                    OpOr:    acc_d = acc_q | b_q;
                    OpAnd:   acc_d = acc_q & b_q;
                    OpXor:   acc_d = acc_q ^ b_q;
                    default: acc_d = acc_q;
                endcase
                if (cnt_q == '0) begin
                    state_d = StDone;
                    res_d   = acc_d;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                if (RES_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            acc_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign CMD_READY = (state_q == StIdle);
    assign RES_VALID = (state_q == StDone);
    assign RES       = res_q;
    assign ERR       = err_q;

`ifdef GATE4_ACCUM_FLAGS_EN
    logic zero_q, parity_q;

    // res_d only moves on entry to DONE, so the flags track RES exactly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            zero_q   <= (res_d == '0);
            parity_q <= ^res_d;
        end
    end

    assign ZERO   = zero_q;
    assign PARITY = parity_q;
`endif

endmodule

// File: tb/tb_gate4_accum_unit.sv
// Directed scoreboard bench for gate4_accum_unit; expected results queued at command issue.
module tb_gate4_accum_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] OP;
    logic [3:0] B;
    logic [2:0] CNT;
    logic       RES_VALID;
    logic       RES_READY;
    logic [3:0] RES;
    logic       ERR;
`ifdef GATE4_ACCUM_FLAGS_EN
    logic       ZERO;
    logic       PARITY;
`endif

    gate4_accum_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .OP        (OP),
        .B         (B),
        .CNT       (CNT),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES       (RES),
        .ERR       (ERR)
`ifdef GATE4_ACCUM_FLAGS_EN
        ,
        .ZERO      (ZERO),
        .PARITY    (PARITY)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] res;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a command; lat = negedges after the accept edge until RES_VALID is seen.
    task automatic send(input logic [2:0] op, input logic [3:0] b, input logic [2:0] cnt,
                        input logic [3:0] eres, input logic eerr, input int lat,
                        input bit junk);
        exp_t e;
        @(negedge CLK);
        check("cmd_ready_idle", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        OP        = op;
        B         = b;
        CNT       = cnt;
        e.res = eres;
        e.err = eerr;
        e.lat = lat;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (junk) begin
            OP  = 3'b000;
            B   = 4'hf;
            CNT = 3'd0;
        end else begin
            CMD_VALID = 1'b0;
        end
    endtask

    task automatic collect(input bit hold);
        exp_t e;
        int   n;
        n = 0;
        while (n < 50) begin
            @(negedge CLK);
            n++;
            if (RES_VALID) break;
        end
        check("res_valid_seen", {31'd0, RES_VALID}, 32'd1);
        CMD_VALID = 1'b0;
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("res", {28'd0, RES}, {28'd0, e.res});
        check("err", {31'd0, ERR}, {31'd0, e.err});
`ifdef GATE4_ACCUM_FLAGS_EN
        check("zero", {31'd0, ZERO}, {31'd0, (e.res == 4'd0)});
        check("parity", {31'd0, PARITY}, {31'd0, ^e.res});
`endif
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                CMD_VALID = ~CMD_VALID;
                OP        = 3'($urandom);
                B         = 4'($urandom);
                @(negedge CLK);
                check("hold_res", {28'd0, RES}, {28'd0, e.res});
                check("hold_err", {31'd0, ERR}, {31'd0, e.err});
                check("hold_valid", {31'd0, RES_VALID}, 32'd1);
                check("hold_cmd_ready", {31'd0, CMD_READY}, 32'd0);
            end
            CMD_VALID = 1'b0;
        end
        RES_READY = 1'b1;
        @(posedge CLK);
        #1;
        RES_READY = 1'b0;
        @(negedge CLK);
        check("valid_drop", {31'd0, RES_VALID}, 32'd0);
        check("back_idle", {31'd0, CMD_READY}, 32'd1);
    endtask

    initial begin
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        OP        = 3'b000;
        B         = 4'h0;
        CNT       = 3'd0;
        RES_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        check("rst_res_valid", {31'd0, RES_VALID}, 32'd0);
        check("rst_res", {28'd0, RES}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
`ifdef GATE4_ACCUM_FLAGS_EN
        check("rst_zero", {31'd0, ZERO}, 32'd1);
        check("rst_parity", {31'd0, PARITY}, 32'd0);
`endif
        // RES_READY while idle must not disturb anything.
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        check("idle_ready_ignored", {31'd0, RES_VALID}, 32'd0);

        send(3'b000, 4'b1011, 3'd0, 4'b1011, 1'b0, 2, 1'b0);
        collect(1'b0);
        send(3'b001, 4'b0000, 3'd0, 4'b0100, 1'b0, 2, 1'b0);
        collect(1'b0);
        send(3'b100, 4'b0101, 3'd1, 4'b0100, 1'b0, 3, 1'b0);
        collect(1'b0);
        send(3'b010, 4'b1011, 3'd0, 4'b1111, 1'b0, 2, 1'b0);
        collect(1'b0);
        send(3'b101, 4'b0000, 3'd0, 4'b1111, 1'b1, 1, 1'b0);
        collect(1'b0);
        send(3'b000, 4'b0011, 3'd0, 4'b0011, 1'b0, 2, 1'b0);
        collect(1'b0);
        // Full-count AND with a LOAD 1111 held on the command bus throughout.
        send(3'b011, 4'b0000, 3'd7, 4'b0000, 1'b0, 9, 1'b1);
        collect(1'b0);
        send(3'b100, 4'b0101, 3'd0, 4'b0101, 1'b0, 2, 1'b0);
        collect(1'b1);
        // Traffic during the hold must not have been latched.
        send(3'b100, 4'b0000, 3'd0, 4'b0101, 1'b0, 2, 1'b0);
        collect(1'b0);

        // Abort a long XOR mid-EXEC.
        @(negedge CLK);
        CMD_VALID = 1'b1;
        OP        = 3'b100;
        B         = 4'b1111;
        CNT       = 3'd5;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("exec_busy", {31'd0, CMD_READY}, 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("abort_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        check("abort_res_valid", {31'd0, RES_VALID}, 32'd0);
        check("abort_res", {28'd0, RES}, 32'd0);
        send(3'b001, 4'b0000, 3'd0, 4'b1111, 1'b0, 2, 1'b0);
        collect(1'b0);

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate4_accum_unit.md
Name: gate4_accum_unit

Overview:
- Sequential 4-bit logic unit sitting directly downstream of the not4/or4/and4/xor4 gate stage.
- Holds an accumulator and applies NOT/OR/AND/XOR with operand B to it, one application per clock, repeated a commanded number of times.
- Accepts commands over a valid/ready handshake and returns each result over a second valid/ready handshake.
- Turns the combinational gate library into a stateful datapath element for later ALU work.

Parameters:
WIDTH, 4, datapath width of accumulator, B and RES.
CNT_W, 3, width of the repeat-count field; a command applies its op CNT+1 times.

Ports:
CLK  input  1  clock, all state changes on rising edge.
RST  input  1  synchronous active-high reset.
CMD_VALID  input  1  command present.
CMD_READY  output  1  unit can accept a command.
OP  input  3  000 LOAD, 001 NOT, 010 OR, 011 AND, 100 XOR, 101-111 illegal.
B  input  WIDTH  operand; ignored by NOT.
CNT  input  CNT_W  repeat count minus one.
RES_VALID  output  1  result present.
RES_READY  input  1  consumer accepts result.
RES  output  WIDTH  accumulator value at completion.
ERR  output  1  last command had an illegal OP.

Behaviour:
- Reset: RST sampled high at a rising edge forces state IDLE, ACC=0, RES=0, ERR=0, RES_VALID=0, CMD_READY=1. The step counter and the latched OP/B are cleared.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&&CMD_READY at an edge, latch OP, B and CNT into internal registers; later changes on the command inputs have no effect.
  - Legal OP: go to EXEC with step counter = CNT.
  - Illegal OP: go to DONE, ERR=1, ACC unchanged.
- EXEC:
  - CMD_READY=0.
  - Each edge applies the latched op: LOAD ACC=B; NOT ACC=~ACC; OR ACC=ACC|B; AND ACC=ACC&B; XOR ACC=ACC^B.
  - If counter==0 after this application, go to DONE; otherwise decrement the counter.
  - Exactly CNT+1 applications occur, so EXEC lasts CNT+1 cycles.
- DONE:
  - RES_VALID=1, RES=ACC, ERR valid.
  - RES, ERR and RES_VALID hold stable until RES_READY is high at an edge, then go to IDLE with RES_VALID=0.
  - CMD_READY=0 throughout DONE; no command/result overlap.
- Latency: accept edge t. Final application at edge t+CNT+1. RES_VALID is high in the cycle after edge t+CNT+1. Minimum is CNT=0, giving RES_VALID one cycle after the accept edge.
- ERR is cleared on the next legal command accept.
- ACC persists across commands; only LOAD and RST set it explicitly.
- Boundaries:
  - CNT all-ones gives 2^CNT_W applications with no counter wrap.
  - RES_READY high while RES_VALID=0 is ignored.
  - CMD_VALID outside IDLE is ignored, with no latching.
  - RST high mid-EXEC or in DONE aborts immediately to the reset values; a pending result is dropped.
  - All arithmetic is bitwise at WIDTH bits; there is no carry.

Optional Feature:
- GATE4_ACCUM_FLAGS_EN defined:
  - Adds outputs ZERO (1 bit, RES==0) and PARITY (1 bit, XOR-reduce of RES).
  - Both are registered, update together with RES on entry to DONE, and reset to ZERO=1, PARITY=0.
- Macro undefined: the ports and logic are absent and the interface is exactly as listed above.

Test Plan:
- After RST, command LOAD B=1011 CNT=0 -> RES_VALID the cycle after accept, RES=1011, ERR=0.
- From ACC=1011, command NOT CNT=0 -> RES=0100. Then XOR B=0101 CNT=1 -> two EXEC cycles, RES=0100 (double XOR cancels), RES_VALID 2 cycles after accept.
- From ACC=0100, command OR B=1011 CNT=0 -> RES=1111. Then AND B=0000 CNT=7 -> 8 EXEC cycles, RES=0000; with GATE4_ACCUM_FLAGS_EN, ZERO=1 and PARITY=0.
- Command OP=101 with ACC=1111 -> next cycle RES_VALID=1, ERR=1, RES=1111. The following legal LOAD 0011 gives ERR=0, RES=0011.
- Hold RES_READY=0 for 5 cycles in DONE while toggling CMD_VALID, OP and B -> RES, ERR and RES_VALID stay stable and CMD_READY stays 0. RES_READY=1 returns the unit to IDLE the next cycle.
- Assert RST during EXEC of XOR CNT=5 -> next cycle IDLE, ACC=0, RES_VALID=0, CMD_READY=1. A subsequent NOT CNT=0 gives RES=1111.
